ifetch_queue: RTL and testbench
===============================

IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, prefetch-queue entries (power of two, >=2).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 redirect  input  1  branch/jump taken; flush and refetch.
REQ-006 redirect_pc  input  32  new fetch address, valid with redirect.
REQ-007 hold  input  1  decode stall; head entry not consumed.
REQ-008 imem_req  output  1  single-cycle fetch request pulse.
REQ-009 imem_addr  output  32  word-aligned fetch address, valid with imem_req.
REQ-010 imem_ack  input  1  response strobe, 1..N cycles after imem_req.
REQ-011 imem_data  input  32  instruction word, valid with imem_ack.
REQ-012 inst_valid  output  1  head entry present.
REQ-013 inst  output  32  head instruction; 32'h0000_0000 (NOP) when queue empty.
REQ-014 pc4  output  32  head entry address + 4; 0 when queue empty.

Function
REQ-015 SHALL hold fetch PC, queue count, an outstanding flag (max one request in flight) and a drop flag.
REQ-016 imem_req SHALL be combinational: high when not in reset, redirect low, drop low, (outstanding low or imem_ack high), and count+outstanding < DEPTH.
REQ-017 imem_addr SHALL equal the fetch PC; fetch PC SHALL advance by 4 on each issued request, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-018 On imem_ack with drop low and redirect low, SHALL write {imem_data, addr+4} at the tail; inst_valid high from the next cycle (min fetch-to-valid latency 2 cycles with 1-cycle memory).
REQ-019 Head is consumed (popped) at the edge where inst_valid=1 and hold=0; push and pop in the same cycle SHALL keep count unchanged.
REQ-020 Queue SHALL never overflow; imem_ack with count==DEPTH is impossible by REQ-016 and SHALL be flagged by an assertion.
REQ-021 On redirect: queue count cleared, fetch PC <= {redirect_pc[31:2],2'b00}, no request that cycle, first request to redirect_pc next cycle.
REQ-022 Redirect with a request outstanding and no imem_ack that cycle SHALL set drop; the next imem_ack SHALL be discarded and clear drop and outstanding.
REQ-023 Redirect coinciding with imem_ack SHALL discard that response and leave drop clear.
REQ-024 Redirect coinciding with a pop SHALL take priority; the pop is absorbed by the flush.
REQ-025 hold SHALL not stall fetching; prefetch continues until the queue is full.
REQ-026 Queue SHALL be a circular buffer with wrap-around read/write pointers of log2(DEPTH) bits and a separate count of log2(DEPTH)+1 bits.

Reset
REQ-027 While rst is high: fetch PC=RESET_PC, count=0, pointers=0, outstanding=0, drop=0, imem_req=0, inst_valid=0, inst=0, pc4=0.
REQ-028 Reset asserted mid-request SHALL abandon it; an imem_ack after reset release with outstanding=0 SHALL be ignored.
REQ-029 First imem_req (address RESET_PC) SHALL occur in the first cycle after rst deasserts.

Structure
REQ-030 RESET_PC default and the NOP encoding SHALL live in the shared CPU package with the opcode constants.
REQ-031 The circular buffer SHALL be one sub-module, ifq_fifo (push, pop, flush, full, empty, count).
REQ-032 ifetch_queue SHALL replace direct PC/instruction-memory wiring in the IF stage; its inst/pc4 feed the IF/ID pipeline register.

Verification
REQ-033 Reset release, 1-cycle memory returning 0x20010005 at addr 0, hold=0 -> imem_req at addr 0 cycle 1, inst_valid cycle 3 with inst=0x20010005, pc4=4.
REQ-034 hold=1 for 10 cycles, 1-cycle memory -> exactly 4 requests (0,4,8,C), count=4, imem_req low; release hold -> entries popped in order, fetching resumes at 0x10.
REQ-035 3-cycle memory, redirect to 0x40 one cycle after request to 0x8 -> response for 0x8 dropped, next request 0x40, first valid pc4=0x44.
REQ-036 redirect to 0x103 in the same cycle as imem_ack -> ack discarded, queue empty, next imem_addr=0x100.
REQ-037 redirect_pc=0xFFFF_FFFC -> requests 0xFFFF_FFFC then 0x0; pc4 of the first entry = 0x0.
REQ-038 rst pulsed with one request outstanding and 2 entries queued -> all outputs 0 immediately; late imem_ack ignored; next request at RESET_PC.

Source files
------------

// File: rtl/ifetch_queue_pkg.sv
// Shared CPU package: reset fetch address, NOP encoding, opcode constants and
// the prefetch queue entry layout used by the instruction fetch stage.
package ifetch_queue_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0000;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
  } ifq_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_queue_fifo.sv
// Circular prefetch buffer: power-of-two depth, wrapping read/write pointers
// and a separate occupancy count. Flush empties it in one edge.
module ifq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)
        count <= count + CW'(1);
      else if (do_pop && !do_push)
        count <= count - CW'(1);
    end
  end

  // Storage needs no reset: only slots below count are ever read out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/ifetch_queue.sv
// IF stage prefetch queue: one fetch in flight, responses queued as
// {instruction, pc+4} for the IF/ID register; redirects flush and refetch.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        hold,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] pc4
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic          outstanding;
  logic          drop;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  ifq_entry_t    wr_entry;
  ifq_entry_t    rd_entry;

  // The in-flight request reserves a slot, so the queue can never overflow.
  assign imem_req = !rst && !redirect && !drop && (!outstanding || imem_ack)
                    && ((32'(count) + 32'(outstanding)) < 32'(DEPTH));
  assign imem_addr = fetch_pc;

  assign push     = imem_ack && outstanding && !drop && !redirect;
  assign pop      = inst_valid && !hold && !redirect;
  assign wr_entry = '{inst: imem_data, pc4: req_pc + 32'd4};

  assign inst_valid = !empty;
  assign inst       = empty ? NOP_INST : rd_entry.inst;
  assign pc4        = empty ? 32'd0 : rd_entry.pc4;

  ifq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(ifq_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .flush   (redirect),
    .wr_data (wr_entry),
    .rd_data (rd_entry),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // A redirect with a fetch still pending marks its eventual response as stale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      req_pc      <= RESET_PC;
      outstanding <= 1'b0;
      drop        <= 1'b0;
    end else if (redirect) begin
      fetch_pc    <= word_align(redirect_pc);
      outstanding <= outstanding && !imem_ack;
      drop        <= outstanding && !imem_ack;
    end else begin
      if (imem_req) begin
        fetch_pc <= fetch_pc + 32'd4;
        req_pc   <= fetch_pc;
      end
      if (imem_req)
        outstanding <= 1'b1;
      else if (imem_ack)
        outstanding <= 1'b0;
      if (imem_ack) drop <= 1'b0;
    end
  end

  ifq_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(imem_ack && outstanding && full));

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: behavioural instruction memory with programmable
// latency plus a scoreboard of expected {inst, pc4} entries in fetch order.
module tb_ifetch_queue;
  import ifetch_queue_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk         = 1'b0;
  logic        rst         = 1'b1;
  logic        redirect    = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        hold        = 1'b0;
  logic        imem_ack    = 1'b0;
  logic [31:0] imem_data   = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] pc4;

  int errors = 0;
  int checks = 0;
  int pops   = 0;
  int mem_lat = 1;

  bit          pend_valid = 1'b0;
  logic [31:0] pend_addr  = 32'd0;
  int          pend_wait  = 0;

  ifq_entry_t exp_q[$];

  ifetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .hold        (hold),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .pc4         (pc4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h2001_0005;
  endfunction

  // Memory responder: answers the request seen mid-cycle mem_lat cycles later.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      imem_ack  = 1'b0;
      imem_data = 32'd0;
      if (pend_valid) begin
        pend_wait--;
        if (pend_wait <= 0) begin
          imem_ack   = 1'b1;
          imem_data  = mem_word(pend_addr);
          pend_valid = 1'b0;
        end
      end
      @(negedge clk);
      if (imem_req === 1'b1) begin
        pend_valid = 1'b1;
        pend_addr  = imem_addr;
        pend_wait  = mem_lat;
      end
    end
  end

  // Scoreboard: every request expects an entry; redirect or reset voids them all.
  always @(negedge clk) begin
    ifq_entry_t e;
    ifq_entry_t got;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (inst_valid !== 1'b1) begin
        checks++;
        if ({inst, pc4} !== 64'd0) begin
          errors++;
          $display("[TB] FAIL empty_outputs: inst=%h pc4=%h, want 0/0", inst, pc4);
        end
      end else if (!hold && !redirect) begin
        checks++;
        pops++;
        got = '{inst: inst, pc4: pc4};
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL pop_unexpected: inst=%h pc4=%h, want no entry", inst, pc4);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("[TB] FAIL pop_entry: inst=%h pc4=%h, want inst=%h pc4=%h",
                     inst, pc4, e.inst, e.pc4);
          end
        end
      end
      if (redirect) exp_q.delete();
      if (imem_req === 1'b1) begin
        e.inst = mem_word(imem_addr);
        e.pc4  = imem_addr + 32'd4;
        exp_q.push_back(e);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] timeout");
  end

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    redirect = 1'b0;
    rst      = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  task automatic test_reset();
    hold = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_req: got %b want 0", imem_req);
    end
    checks++;
    if ({inst_valid, inst, pc4} !== 65'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: valid=%b inst=%h pc4=%h want 0", inst_valid, inst, pc4);
    end
  endtask

  task automatic test_first_fetch();
    mem_lat = 1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, RESET_PC}) begin
      errors++;
      $display("[TB] FAIL first_req: req=%b addr=%h want 1/%h", imem_req, imem_addr, RESET_PC);
    end
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL early_valid: got %b want 0", inst_valid);
    end
    @(negedge clk);
    checks++;
    if ({inst_valid, inst, pc4} !== {1'b1, 32'h2001_0005, 32'h4}) begin
      errors++;
      $display("[TB] FAIL first_inst: valid=%b inst=%h pc4=%h want 1/20010005/4",
               inst_valid, inst, pc4);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_hold_full();
    int  n;
    bit  found;
    hold    = 1'b1;
    mem_lat = 1;
    do_reset(4);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req === 1'b1) begin
        checks++;
        if (imem_addr !== RESET_PC + 32'(n * 4)) begin
          errors++;
          $display("[TB] FAIL hold_req_addr: got %h want %h", imem_addr, RESET_PC + 32'(n * 4));
        end
        n++;
      end
    end
    checks++;
    if (n != DEPTH) begin
      errors++;
      $display("[TB] FAIL hold_req_count: got %0d want %0d", n, DEPTH);
    end
    checks++;
    if ({imem_req, inst_valid, inst, pc4} !== {1'b0, 1'b1, mem_word(RESET_PC), RESET_PC + 32'd4}) begin
      errors++;
      $display("[TB] FAIL hold_full_state: req=%b valid=%b inst=%h pc4=%h", imem_req, inst_valid, inst, pc4);
    end
    @(posedge clk);
    #1;
    hold  = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (imem_req === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found || imem_addr !== 32'h10) begin
      errors++;
      $display("[TB] FAIL resume_addr: found=%b addr=%h want 1/00000010", found, imem_addr);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_redirect_outstanding();
    bit found;
    hold    = 1'b0;
    mem_lat = 3;
    do_reset(5);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (imem_req === 1'b1 && imem_addr === 32'h8) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL req8_seen: got none want request to 00000008");
    end
    @(posedge clk);
    #1;
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    @(negedge clk);
    checks++;
    if ({imem_req, inst_valid} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL redirect_cycle: req=%b valid=%b want 0/1", imem_req, inst_valid);
    end
    @(posedge clk);
    #1;
    redirect = 1'b0;
    @(negedge clk);
    checks++;
    if ({imem_req, inst_valid} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL after_redirect: req=%b valid=%b want 0/0", imem_req, inst_valid);
    end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (imem_req === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found || imem_addr !== 32'h40) begin
      errors++;
      $display("[TB] FAIL redirect_target: found=%b addr=%h want 1/00000040", found, imem_addr);
    end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (inst_valid === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found || {inst, pc4} !== {mem_word(32'h40), 32'h44}) begin
      errors++;
      $display("[TB] FAIL redirect_entry: found=%b inst=%h pc4=%h want %h/00000044",
               found, inst, pc4, mem_word(32'h40));
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_redirect_with_ack();
    hold    = 1'b0;
    mem_lat = 1;
    do_reset(5);
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_ack_req: got %b want 1", imem_req);
    end
    @(posedge clk);
    #1;
    redirect    = 1'b1;
    redirect_pc = 32'h103;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ack_redirect_req: got %b want 0", imem_req);
    end
    @(posedge clk);
    #1;
    redirect = 1'b0;
    @(negedge clk);
    checks++;
    if ({imem_req, imem_addr, inst_valid} !== {1'b1, 32'h100, 1'b0}) begin
      errors++;
      $display("[TB] FAIL ack_redirect_next: req=%b addr=%h valid=%b want 1/00000100/0",
               imem_req, imem_addr, inst_valid);
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_pc_wrap();
    hold    = 1'b1;
    mem_lat = 1;
    do_reset(5);
    @(negedge clk);
    @(posedge clk);
    #1;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    @(negedge clk);
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
      errors++;
      $display("[TB] FAIL wrap_first: req=%b addr=%h want 1/fffffffc", imem_req, imem_addr);
    end
    @(negedge clk);
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      errors++;
      $display("[TB] FAIL wrap_second: req=%b addr=%h want 1/00000000", imem_req, imem_addr);
    end
    @(negedge clk);
    checks++;
    if ({inst_valid, inst, pc4} !== {1'b1, mem_word(32'hFFFF_FFFC), 32'h0}) begin
      errors++;
      $display("[TB] FAIL wrap_entry: valid=%b inst=%h pc4=%h want 1/%h/00000000",
               inst_valid, inst, pc4, mem_word(32'hFFFF_FFFC));
    end
    @(posedge clk);
    #1;
    hold = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid_request();
    hold    = 1'b1;
    mem_lat = 2;
    do_reset(5);
    repeat (5) @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_pre_valid: got %b want 1", inst_valid);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    checks++;
    if ({imem_req, inst_valid, inst, pc4} !== 66'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset_outputs: req=%b valid=%b inst=%h pc4=%h want 0",
               imem_req, inst_valid, inst, pc4);
    end
    @(posedge clk);
    #1;
    rst  = 1'b0;
    hold = 1'b0;
    @(negedge clk);
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, RESET_PC}) begin
      errors++;
      $display("[TB] FAIL mid_restart: req=%b addr=%h want 1/%h", imem_req, imem_addr, RESET_PC);
    end
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL late_ack_ignored: valid=%b want 0", inst_valid);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int start_pops;
    hold    = 1'b0;
    mem_lat = 1;
    do_reset(5);
    start_pops = pops;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      hold    = ($urandom_range(0, 3) == 0);
      mem_lat = int'($urandom_range(1, 2));
    end
    @(posedge clk);
    #1;
    hold    = 1'b0;
    mem_lat = 1;
    repeat (10) @(negedge clk);
    checks++;
    if (pops - start_pops < 10) begin
      errors++;
      $display("[TB] FAIL stream_throughput: pops=%0d want >=10", pops - start_pops);
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_hold_full();
    test_redirect_outstanding();
    test_redirect_with_ack();
    test_pc_wrap();
    test_reset_mid_request();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
